// File: rtl/sumador_operand_loader.sv
// Operand loader for the 8-bit adder: a debounced-by-sync load strobe captures
// operand A then operand B from the pad bus and flags a complete pair.
module sumador_operand_loader #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [WIDTH-1:0] din,
    input  logic             load_btn,
    input  logic             clr,
    output logic [WIDTH-1:0] a_out,
    output logic [WIDTH-1:0] b_out,
    output logic             op_valid,
    output logic [1:0]       state_out,
    output logic [7:0]       op_count
);

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_GOT_A = 2'b01;
    localparam logic [1:0] ST_READY = 2'b10;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   prev_reg;
    logic                   pulse_reg;

    logic [1:0]       state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic             valid_reg, valid_next;
    logic [7:0]       count_reg, count_next;
    logic             load_take;

    assign sync_next[0] = load_btn;

    genvar gi;
    generate
        for (gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_next[gi] = sync_reg[gi-1];
        end
    endgenerate

    // The pulse is registered so the capture lands SYNC_STAGES+1 clocks after
    // the first clock that sees the button high; the chain runs even when ena=0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync_reg  <= sync_next;
            prev_reg  <= sync_reg[SYNC_STAGES-1];
            pulse_reg <= sync_reg[SYNC_STAGES-1] & ~prev_reg;
        end
    end

    assign load_take = ena & pulse_reg;

    always_comb begin
        state_next = state_reg;
        a_next     = a_reg;
        b_next     = b_reg;
        valid_next = valid_reg;
        count_next = count_reg;
        if (clr) begin
            state_next = ST_IDLE;
            a_next     = '0;
            b_next     = '0;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (load_take) begin
                        a_next     = din;
                        state_next = ST_GOT_A;
                    end
                end
                ST_GOT_A: begin
                    if (load_take) begin
                        b_next     = din;
                        valid_next = 1'b1;
                        count_next = count_reg + 8'd1;
                        state_next = ST_READY;
                    end
                end
                ST_READY: begin
                    if (load_take) begin
                        a_next     = din;
                        valid_next = 1'b0;
                        state_next = ST_GOT_A;
                    end
                end
                default: begin
                    // Illegal encoding: recover to IDLE with no pair claimed.
                    state_next = ST_IDLE;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            valid_reg <= 1'b0;
            count_reg <= 8'd0;
        end else begin
            state_reg <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            valid_reg <= valid_next;
            count_reg <= count_next;
        end
    end

    assign a_out     = a_reg;
    assign b_out     = b_reg;
    assign op_valid  = valid_reg;
    assign state_out = state_reg;
    assign op_count  = count_reg;

endmodule
